// File: rtl/store_buffer.sv
// Core-side store buffer: a circular FIFO of {address, data} stores that drains to data memory
// through a req/ack handshake and forwards buffered data to loads.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [2:0]  count,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [2:0]  Full = 3'(DEPTH);

  typedef enum logic {StIdle, StReq} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [2:0]        count_q, count_d;
  logic [31:0]       addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic              push, pop;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic [PtrW-1:0]   fwd_idx;

  // Stall looks only at the registered count, so a pop in the same cycle does not free a slot.
  assign push  = MemWrite && (count_q != Full);
  assign Stall = MemWrite && (count_q == Full);
  assign pop   = (state_q == StReq) && mem_ack;

  assign count     = count_q;
  assign empty     = (count_q == 3'd0);
  assign mem_raddr = ALUResult;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= ALUResult;
      data_mem[wr_ptr_q] <= WriteData;
    end
  end

  // Drain FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Drain FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (count_q != 3'd0) state_d = StReq;
      StReq:   if (pop && (count_d == 3'd0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Drain FSM: outputs; the head entry cannot be overwritten while occupied, so it is stable
  always_comb begin
    mem_req   = (state_q == StReq);
    mem_addr  = addr_mem[rd_ptr_q];
    mem_wdata = data_mem[rd_ptr_q];
  end

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PtrW'(k);
      if ((3'(k) < count_q) && (addr_mem[fwd_idx][31:2] == ALUResult[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
    ReadData = fwd_hit ? fwd_data : mem_rdata;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stores queue expected writes, memory handshakes pop them.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  entry_t      sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        hold = 1'b0;
  logic [31:0] hold_addr, hold_data;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .count     (count),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_fwd();
    logic [31:0] r;
    r = ~ALUResult;
    foreach (sb[i]) if (sb[i].addr[31:2] == ALUResult[31:2]) r = sb[i].data;
    return r;
  endfunction

  // Check everything visible this cycle, update the scoreboard for the coming edge, then clock.
  task automatic step();
    entry_t e;
    logic   exp_stall;
    mem_rdata = ~ALUResult;
    #1;
    exp_stall = MemWrite && (sb.size() == DEPTH);
    check_eq("raddr", mem_raddr, ALUResult);
    check_eq("count", 32'(count), 32'(sb.size()));
    check_eq("empty", 32'(empty), 32'(sb.size() == 0));
    check_eq("stall", 32'(Stall), 32'(exp_stall));
    check_eq("rdata", ReadData, model_fwd());
    if (sb.size() == 0) check_eq("req_idle", 32'(mem_req), 32'd0);
    if (hold) begin
      check_eq("hold_req", 32'(mem_req), 32'd1);
      check_eq("hold_addr", mem_addr, hold_addr);
      check_eq("hold_data", mem_wdata, hold_data);
    end
    if (mem_req && mem_ack) begin
      if (sb.size() == 0) begin
        check_eq("spurious_write", 32'(mem_req), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("wr_addr", mem_addr, e.addr);
        check_eq("wr_data", mem_wdata, e.data);
      end
    end
    hold      = mem_req && !mem_ack;
    hold_addr = mem_addr;
    hold_data = mem_wdata;
    if (MemWrite && !exp_stall) sb.push_back('{addr: ALUResult, data: WriteData});
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    ALUResult = a;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    mem_ack = 1'b1;
    while ((sb.size() != 0 || mem_req) && n < 50) begin
      step();
      n++;
    end
    check_eq("drained", 32'(sb.size()), 32'd0);
    step();
  endtask

  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b1;
    ALUResult = 32'h0;
    WriteData = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #2;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_stall", 32'(Stall), 32'd0);
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single store with ack tied high
    mem_ack = 1'b1;
    store(32'h10, 32'hA5A5A5A5);
    check_eq("single_cnt", 32'(count), 32'd1);
    step();
    check_eq("single_req", 32'(mem_req), 32'd1);
    check_eq("single_addr", mem_addr, 32'h10);
    drain();

    // Fill to full, then one ack frees a slot for the stalled store
    mem_ack = 1'b0;
    store(32'h0, 32'h100);
    store(32'h4, 32'h104);
    store(32'h8, 32'h108);
    store(32'hC, 32'h10C);
    MemWrite  = 1'b1;
    ALUResult = 32'h20;
    WriteData = 32'h120;
    #1;
    check_eq("full_cnt", 32'(count), 32'd4);
    check_eq("full_stall", 32'(Stall), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    MemWrite = 1'b0;
    check_eq("after_full_cnt", 32'(count), 32'd4);
    drain();

    // Forwarding picks the youngest matching store
    mem_ack = 1'b0;
    store(32'h40, 32'h11111111);
    store(32'h40, 32'h22222222);
    ALUResult = 32'h42;
    step();
    check_eq("fwd_young", ReadData, 32'h22222222);
    ALUResult = 32'h44;
    mem_rdata = ~ALUResult;
    #1;
    check_eq("fwd_miss", ReadData, 32'hFFFFFFBB);
    step();
    drain();

    // Ordered writes under random ack delays
    store(32'h200, $urandom);
    store(32'h204, $urandom);
    store(32'h208, $urandom);
    for (int w = 0; w < 3; w++) begin
      int dly;
      dly = $urandom_range(0, 5);
      mem_ack = 1'b0;
      for (int j = 0; j < dly; j++) step();
      mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    check_eq("rand_done", 32'(count), 32'd0);
    step();

    // Enqueue and ack on the same edge at count=2, wrapping the pointers
    store(32'h300, 32'h300);
    store(32'h304, 32'h304);
    for (int it = 0; it < 8; it++) begin
      mem_ack   = 1'b1;
      MemWrite  = 1'b1;
      ALUResult = 32'h400 + 32'(it * 4);
      WriteData = 32'hC0DE0000 + 32'(it);
      step();
      check_eq("simul_cnt", 32'(count), 32'd2);
    end
    MemWrite = 1'b0;
    drain();

    // Asynchronous reset mid-drain discards pending stores
    mem_ack = 1'b0;
    store(32'h500, 32'h1);
    store(32'h504, 32'h2);
    store(32'h508, 32'h3);
    check_eq("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(mem_req), 32'd0);
    check_eq("mid_rst_cnt", 32'(count), 32'd0);
    sb.delete();
    hold = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ack = 1'b1;
    store(32'h8, 32'h88888888);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 MemWrite  input  1  core store strobe for the current cycle.
REQ-005 ALUResult  input  32  core data address, byte address; word compare uses bits [31:2].
REQ-006 WriteData  input  32  core store data.
REQ-007 ReadData  output  32  load data returned to core, combinational.
REQ-008 Stall  output  1  core must hold the current instruction and PC.
REQ-009 mem_raddr  output  32  read address to data memory, equal to ALUResult.
REQ-010 mem_rdata  input  32  data memory read data, combinational from mem_raddr.
REQ-011 mem_req  output  1  registered write request to data memory.
REQ-012 mem_addr  output  32  write address, valid while mem_req=1.
REQ-013 mem_wdata  output  32  write data, valid while mem_req=1.
REQ-014 mem_ack  input  1  memory accepted the write this cycle.
REQ-015 count  output  3  occupied entries, range 0..DEPTH.
REQ-016 empty  output  1  high when count=0.

Function
REQ-017 Circular FIFO: write pointer, read pointer and count; both pointers wrap modulo DEPTH.
REQ-018 Enqueue: at a rising edge with MemWrite=1 and count<DEPTH, the entry {ALUResult, WriteData} is written at the write pointer, and the write pointer advances.
REQ-019 Stall = MemWrite AND (count==DEPTH), combinational from registered count; no enqueue while Stall=1.
REQ-020 No store coalescing: each accepted store produces exactly one memory write, in program order.
REQ-021 Load forwarding: ReadData is the data of the youngest valid entry whose addr[31:2] equals ALUResult[31:2]; if there is no match, ReadData = mem_rdata.
REQ-022 Forwarding includes the entry currently presented on mem_addr, until its pop.
REQ-023 Drain FSM has two states, IDLE and REQ.
REQ-024 IDLE: mem_req=0; if count>0 at an edge, go to REQ with mem_req=1 and mem_addr/mem_wdata = head entry.
REQ-025 REQ: mem_req, mem_addr and mem_wdata stay stable until mem_ack=1 is sampled.
REQ-026 REQ with mem_ack=1 at an edge: pop the head (read pointer advances); if entries remain after the pop, stay in REQ and present the new head next cycle, else go to IDLE with mem_req=0.
REQ-027 mem_ack while in IDLE is ignored.
REQ-028 Enqueue and pop in the same edge: count unchanged, both pointers advance.
REQ-029 Full with a simultaneous pop: Stall stays asserted for that cycle (conservative); the store is accepted on the next edge.
REQ-030 Enqueue into an empty buffer: the entry is visible to forwarding from the next cycle; mem_req rises one edge after the enqueue.
REQ-031 Minimum latency from store acceptance to mem_req=1 is 1 cycle; throughput is one write per mem_ack cycle.
REQ-032 count never exceeds DEPTH and never underflows; count is not decremented without a pop.

Reset
REQ-033 reset=0 immediately, with no clock edge, forces: count=0, both pointers 0, state IDLE, mem_req=0, empty=1, Stall=0.
REQ-034 Reset during REQ drops mem_req asynchronously, and all pending stores are discarded.
REQ-035 Entry storage is not reset; invalid entries never forward.
REQ-036 First enqueue is accepted at the first rising edge after reset is released.

Verification
REQ-037 Single store: MemWrite with addr 0x10, data 0xA5A5A5A5, mem_ack tied 1 -> mem_req=1 next cycle with addr 0x10, data 0xA5A5A5A5, then count returns to 0.
REQ-038 Fill to full: 5 back-to-back stores to 0x0,0x4,0x8,0xC,0x20 with mem_ack=0 -> count=4 and Stall=1 on the 5th; raise mem_ack for one cycle -> 0x0 drains and 0x20 is accepted the following edge.
REQ-039 Forwarding: store 0x11111111 then 0x22222222 to 0x40, mem_ack=0, load 0x42 -> ReadData=0x22222222; load 0x44 -> ReadData=mem_rdata.
REQ-040 Order and handshake: 3 stores, random mem_ack delay 0-5 cycles -> writes appear in order, and mem_addr/mem_wdata are stable while mem_req=1 and mem_ack=0.
REQ-041 Simultaneous events: enqueue and ack in the same edge at count=2 -> count stays 2, pointers wrap correctly across 8 iterations.
REQ-042 Reset mid-operation: assert reset with count=3 and mem_req=1 -> mem_req=0 and count=0 without a clock edge; after release, a store to 0x8 drains correctly.
